// File: rtl/result_bcd_serializer.sv
// Latches a binary result, converts it to BCD with one double-dabble shift per cycle, then streams DIGITS digits MSD first.
// First digit appears 12 cycles after acceptance; no backpressure, and words arriving while busy are dropped. Blanking: RESULT_BCD_SERIALIZER_LZ_SUPPRESS_EN.
module result_bcd_serializer #(
  parameter int DATA_W = 11,
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in,
  output logic              busy,
  output logic              out_valid,
  output logic [3:0]        out,
  output logic              out_last
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_SEND
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               out_valid_q, out_valid_d;
  logic [3:0]         out_q, out_d;
  logic               out_last_q, out_last_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [3:0]         digit;
  logic [3:0]         digit_shown;

  always_comb begin
    bcd_adj = bcd_q;
    digit   = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      if (IDX_W'(i) == idx_q) begin
        digit = bcd_q[4*i +: 4];
      end
    end
  end

`ifdef RESULT_BCD_SERIALIZER_LZ_SUPPRESS_EN
  logic higher_zero;

  // A zero is blanked only while every more-significant digit is also zero; the units digit never is.
  always_comb begin
    higher_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if ((IDX_W'(i) > idx_q) && (bcd_q[4*i +: 4] != 4'd0)) begin
        higher_zero = 1'b0;
      end
    end
    digit_shown = (higher_zero && (digit == 4'd0) && (idx_q != '0)) ? 4'hF : digit;
  end
`else
  always_comb begin
    digit_shown = digit;
  end
`endif

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    out_d       = 4'd0;
    out_last_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          bin_d   = in;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_CONV;
        end
      end

      S_CONV: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
        bin_d = {bin_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          idx_d   = IDX_W'(DIGITS - 1);
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        // The cycle after the units digit closes the word.
        if (out_last_q) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
          out_d       = digit_shown;
          out_last_d  = (idx_q == '0);
          idx_d       = idx_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= 4'd0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_result_bcd_serializer.sv
// Directed bench for result_bcd_serializer: digit values, exact cycle timing, drop-while-busy and async reset.
module tb_result_bcd_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [10:0] in_dat;
  logic        busy;
  logic        out_valid;
  logic [3:0]  out;
  logic        out_last;

  int errors = 0;
  int checks = 0;
  int nvalid = 0;

`ifdef RESULT_BCD_SERIALIZER_LZ_SUPPRESS_EN
  localparam logic [15:0] EXP_0   = 16'hFFF0;
  localparam logic [15:0] EXP_7   = 16'hFFF7;
  localparam logic [15:0] EXP_9   = 16'hFFF9;
  localparam logic [15:0] EXP_42  = 16'hFF42;
  localparam logic [15:0] EXP_100 = 16'hF100;
`else
  localparam logic [15:0] EXP_0   = 16'h0000;
  localparam logic [15:0] EXP_7   = 16'h0007;
  localparam logic [15:0] EXP_9   = 16'h0009;
  localparam logic [15:0] EXP_42  = 16'h0042;
  localparam logic [15:0] EXP_100 = 16'h0100;
`endif

  result_bcd_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in        (in_dat),
    .busy      (busy),
    .out_valid (out_valid),
    .out       (out),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) nvalid++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the next posedge is E0. Optionally injects a second
  // word just before edge E<drop_at>, and optionally leaves in_valid high.
  task automatic run_word(input string tag, input logic [10:0] v, input logic [15:0] exp,
                          input int drop_at, input logic [10:0] drop_v, input bit hold);
    in_valid = 1'b1;
    in_dat   = v;
    @(posedge clk);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    check({tag, " busy_after_E0"}, 16'(busy), 16'd1);
    for (int n = 1; n <= 16; n++) begin
      if (drop_at == n) begin
        in_valid = 1'b1;
        in_dat   = drop_v;
      end
      @(negedge clk);
      if (drop_at == n && !hold) in_valid = 1'b0;
      if (n == 11) begin
        check({tag, " E11 busy,valid"}, 16'({busy, out_valid}), 16'b10);
      end else if (n >= 12 && n <= 15) begin
        check($sformatf("%s digit%0d valid,last,out", tag, n - 12),
              16'({out_valid, out_last, out}),
              16'({1'b1, (n == 15), exp[15 - 4*(n-12) -: 4]}));
      end else if (n == 16) begin
        check({tag, " E16 idle"}, 16'({busy, out_valid, out_last, out}), 16'd0);
      end
    end
  endtask

  initial begin
    int seen;
    int base;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_dat   = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset outputs", 16'({busy, out_valid, out_last, out}), 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after reset", 16'({busy, out_valid}), 16'd0);

    run_word("w1395", 11'd1395, 16'h1395, 0, 11'd0, 1'b0);
    run_word("w0",    11'd0,    EXP_0,    0, 11'd0, 1'b0);
    run_word("w2047", 11'd2047, 16'h2047, 0, 11'd0, 1'b0);

    // Second word during conversion is dropped; next acceptance at E20.
    run_word("w7drop", 11'd7, EXP_7, 5, 11'd9, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("idle gap", 16'({busy, out_valid}), 16'd0);
    end
    run_word("w9", 11'd9, EXP_9, 0, 11'd0, 1'b0);

    // Async reset mid-conversion.
    in_valid = 1'b1;
    in_dat   = 11'd1234;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async reset busy,valid,out", 16'({busy, out_valid, out}), 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (16) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no digits after reset", 16'(seen), 16'd0);
    run_word("w42", 11'd42, EXP_42, 0, 11'd0, 1'b0);

    // in_valid held high: accepted at E0 and E17 only.
    base = nvalid;
    run_word("w100a", 11'd100, EXP_100, 0, 11'd0, 1'b1);
    run_word("w100b", 11'd100, EXP_100, 0, 11'd0, 1'b0);
    repeat (20) @(negedge clk);
    check("held valid digit count", 16'(nvalid - base), 16'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
